mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter W_SIZE, default 32, data width.
REQ-002 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max wait cycles for load data (1..255).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  pipeline requests an access.
- req_ready  out  1  unit can accept a request.
- req_is_store  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_func3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
- req_wdata  in  W_SIZE  store data, LSB-aligned.
- stall  out  1  pipeline must hold.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  W_SIZE  lane-replicated store data.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  W_SIZE  memory read word.
- ld_valid  out  1  one-cycle pulse: ld_* outputs hold a new load.
- ld_mem_data  out  W_SIZE  captured raw word for the load formatter.
- ld_addr  out  ADDR_W  address of that load.
- ld_func3  out  3  funct3 of that load.
- misaligned  out  1  one-cycle fault pulse.
- timeout  out  1  one-cycle fault pulse.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-006 SHALL drive req_ready = (state==IDLE) & ~rst, and stall = (state!=IDLE).
REQ-007 SHALL accept a request on a rising edge with req_valid & req_ready, registering is_store, addr, func3 and wdata.
REQ-008 SHALL flag an accepted request as misaligned when:
- func3[1:0]==01 and addr[0]==1, or
- func3[1:0]==10 and addr[1:0]!=0.
REQ-009 SHALL, for a misaligned request, pulse misaligned for the cycle after acceptance, issue no memory access, and remain in IDLE.
REQ-010 SHALL, for an aligned request, go to ISSUE and drive mem_en=1 and mem_addr=registered addr for exactly that one cycle.
REQ-011 SHALL generate store byte enables in ISSUE, with lane = addr[1:0] (addr[1] only for SH):
- SB: 4'b0001 << lane.
- SH: 4'b0011 << lane.
- SW: 4'b1111.
- Any other store funct3: treated as SW.
REQ-012 SHALL drive mem_wdata as:
- SB: {4{wdata[7:0]}}.
- SH: {2{wdata[15:0]}}.
- SW: wdata.
REQ-013 SHALL complete a store in ISSUE and return to IDLE, for a total latency of 2 cycles from acceptance to req_ready.
REQ-014 SHALL drive mem_we=0 for loads and in every state other than ISSUE.
REQ-015 SHALL move a load from ISSUE to WAIT, where:
- mem_rvalid=1 captures ld_mem_data=mem_rdata, ld_addr and ld_func3, then goes to DONE.
- A cycle counter starts at 0 and increments each WAIT cycle without mem_rvalid.
REQ-016 SHALL pulse ld_valid for the one DONE cycle, then return to IDLE.
REQ-017 SHALL give minimum load latency (accept -> ld_valid) of 3 cycles when mem_rvalid arrives in the first WAIT cycle.
REQ-018 SHALL handle timeout as follows:
- When the counter reaches TIMEOUT with no mem_rvalid, pulse timeout for one cycle, return to IDLE, and leave ld_* unchanged with ld_valid=0.
- mem_rvalid in the same cycle as expiry takes priority, and no timeout is raised.
REQ-019 SHALL ignore mem_rvalid in IDLE, ISSUE and DONE.
REQ-020 SHALL treat loads with funct3 3, 6 or 7 as word loads for alignment checking and pass func3 through unchanged.
REQ-021 SHALL hold ld_mem_data, ld_addr and ld_func3 stable until the next load capture.

Reset
REQ-022 SHALL, while rst=1, immediately force:
- state=IDLE and counter=0.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- ld_valid=0, ld_mem_data=0, ld_addr=0, ld_func3=0.
- misaligned=0, timeout=0, req_ready=0, stall=0.
REQ-023 SHALL abandon any in-flight access on reset and ignore a mem_rvalid arriving after reset deassertion while in IDLE.

Verification
REQ-024 SHALL pass these directed scenarios:
- LW at 0x0104, mem_rvalid one cycle after mem_en with 0xDEADBEEF -> ld_valid 3 cycles after accept, ld_mem_data=0xDEADBEEF, ld_addr=0x0104, ld_func3=2.
- SB at 0x0203, wdata=0x000000A5 -> one mem_en cycle, mem_we=4'b1000, mem_wdata=0xA5A5A5A5, req_ready high 2 cycles after accept.
- SH at 0x0012, wdata=0x1234 -> mem_we=4'b1100, mem_wdata=0x12341234; LH at 0x0011 -> misaligned pulse, mem_en never asserted.
- Load with TIMEOUT=15 and no mem_rvalid -> timeout pulse, no ld_valid, back in IDLE; a second case with rvalid on the expiry cycle -> ld_valid, no timeout.
- rst asserted during WAIT -> all outputs 0 asynchronously; mem_rvalid after release -> no ld_valid, req_ready=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the pipeline and a simple
// single-strobe memory port. Checks alignment, builds byte enables and
// lane-replicated store data, and waits a bounded number of cycles for load data.
module mem_access_unit #(
  parameter int W_SIZE  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_func3,
  input  logic [W_SIZE-1:0] req_wdata,
  output logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W_SIZE-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [W_SIZE-1:0] mem_rdata,
  output logic              ld_valid,
  output logic [W_SIZE-1:0] ld_mem_data,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [2:0]        ld_func3,
  output logic              misaligned,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Last WAIT cycle in which the counter may still see data before expiry.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              misaligned_q, misaligned_d;
  logic              timeout_q, timeout_d;

  logic              is_store_q, is_store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        func3_q, func3_d;
  logic [W_SIZE-1:0] wdata_q, wdata_d;

  logic [W_SIZE-1:0] ld_mem_data_q, ld_mem_data_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [2:0]        ld_func3_q, ld_func3_d;

  logic              accept;
  logic              req_misaligned;

  // funct3[1] set means word access (covers LW/SW and the reserved codes
  // 3, 6, 7); otherwise funct3[0] set means halfword.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1])      return (a != 2'b00);
    else if (f3[0]) return a[0];
    else            return 1'b0;
  endfunction

  // Byte enables for a store; halfwords only use addr[1] to pick the lane.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the LSB-aligned store data across every lane it could land in.
  function automatic logic [W_SIZE-1:0] store_data(input logic [2:0] f3,
                                                   input logic [W_SIZE-1:0] wd);
    case (f3)
      3'b000:  return W_SIZE'({4{wd[7:0]}});
      3'b001:  return W_SIZE'({2{wd[15:0]}});
      default: return wd;
    endcase
  endfunction

  assign accept         = req_valid & req_ready;
  assign req_misaligned = is_misaligned(req_func3, req_addr[1:0]);

  // Control state, fault pulses and the load result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      misaligned_q  <= 1'b0;
      timeout_q     <= 1'b0;
      ld_mem_data_q <= '0;
      ld_addr_q     <= '0;
      ld_func3_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      misaligned_q  <= misaligned_d;
      timeout_q     <= timeout_d;
      ld_mem_data_q <= ld_mem_data_d;
      ld_addr_q     <= ld_addr_d;
      ld_func3_q    <= ld_func3_d;
    end
  end

  // Request fields are only observed while the FSM is away from IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    is_store_q <= is_store_d;
    addr_q     <= addr_d;
    func3_q    <= func3_d;
    wdata_q    <= wdata_d;
  end

  // Latch the request on acceptance, otherwise hold.
  always_comb begin
    is_store_d = is_store_q;
    addr_d     = addr_q;
    func3_d    = func3_q;
    wdata_d    = wdata_q;
    if (accept) begin
      is_store_d = req_is_store;
      addr_d     = req_addr;
      func3_d    = req_func3;
      wdata_d    = req_wdata;
    end
  end

  // Next state, wait counter, fault pulses and load capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    misaligned_d  = 1'b0;
    timeout_d     = 1'b0;
    ld_mem_data_d = ld_mem_data_q;
    ld_addr_d     = ld_addr_q;
    ld_func3_d    = ld_func3_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (req_misaligned) misaligned_d = 1'b1;
          else                state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = is_store_q ? IDLE : WAIT;
      end
      WAIT: begin
        // Data arriving on the expiry cycle still wins over the timeout.
        if (mem_rvalid) begin
          ld_mem_data_d = mem_rdata;
          ld_addr_d     = addr_q;
          ld_func3_d    = func3_q;
          cnt_d         = '0;
          state_d       = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Memory strobes and handshake outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == IDLE) & ~rst;
    stall     = (state_q != IDLE);
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_valid  = 1'b0;
    case (state_q)
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        if (is_store_q) begin
          mem_we    = store_be(func3_q, addr_q[1:0]);
          mem_wdata = store_data(func3_q, wdata_q);
        end
      end
      DONE:    ld_valid = 1'b1;
      default: ;
    endcase
  end

  assign ld_mem_data = ld_mem_data_q;
  assign ld_addr     = ld_addr_q;
  assign ld_func3    = ld_func3_q;
  assign misaligned  = misaligned_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, alignment faults,
// timeout expiry and asynchronous reset during a pending load.
module tb_mem_access_unit;

  localparam int W_SIZE  = 32;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_func3;
  logic [W_SIZE-1:0] req_wdata;
  logic              stall;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [W_SIZE-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [W_SIZE-1:0] mem_rdata;
  logic              ld_valid;
  logic [W_SIZE-1:0] ld_mem_data;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_func3;
  logic              misaligned;
  logic              timeout;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.W_SIZE(W_SIZE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_mem_data(ld_mem_data), .ld_addr(ld_addr),
    .ld_func3(ld_func3), .misaligned(misaligned), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic st, input logic [ADDR_W-1:0] a,
                         input logic [2:0] f3, input logic [W_SIZE-1:0] wd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_addr     = a;
    req_func3    = f3;
    req_wdata    = wd;
    tick();
    req_valid    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0;
    req_func3 = '0; req_wdata = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_ld_valid",  32'(ld_valid),  32'd0);
    chk("rst_ld_data",   ld_mem_data,    32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);

    // LW 0x0104, data in first WAIT cycle
    request(1'b0, 16'h0104, 3'd2, 32'h0);
    chk("lw_issue_en",   32'(mem_en),   32'd1);
    chk("lw_issue_addr", 32'(mem_addr), 32'h0104);
    chk("lw_issue_we",   32'(mem_we),   32'h0);
    chk("lw_issue_ready", 32'(req_ready), 32'd0);
    tick();
    chk("lw_wait_en", 32'(mem_en), 32'd0);
    chk("lw_wait_stall", 32'(stall), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("lw_ld_valid", 32'(ld_valid), 32'd1);
    chk("lw_ld_data",  ld_mem_data,   32'hDEADBEEF);
    chk("lw_ld_addr",  32'(ld_addr),  32'h0104);
    chk("lw_ld_func3", 32'(ld_func3), 32'd2);
    tick();
    chk("lw_after_valid", 32'(ld_valid), 32'd0);
    chk("lw_after_ready", 32'(req_ready), 32'd1);
    chk("lw_hold_data",   ld_mem_data, 32'hDEADBEEF);

    // SB 0x0203
    request(1'b1, 16'h0203, 3'd0, 32'h000000A5);
    chk("sb_en",    32'(mem_en),    32'd1);
    chk("sb_we",    32'(mem_we),    32'b1000);
    chk("sb_wdata", mem_wdata,      32'hA5A5A5A5);
    chk("sb_addr",  32'(mem_addr),  32'h0203);
    tick();
    chk("sb_ready", 32'(req_ready), 32'd1);
    chk("sb_en_off", 32'(mem_en),   32'd0);
    chk("sb_we_off", 32'(mem_we),   32'd0);

    // SH 0x0012
    request(1'b1, 16'h0012, 3'd1, 32'h00001234);
    chk("sh_we",    32'(mem_we), 32'b1100);
    chk("sh_wdata", mem_wdata,   32'h12341234);
    tick();

    // Store with reserved funct3 behaves as SW
    request(1'b1, 16'h0008, 3'd3, 32'h11223344);
    chk("s3_we",    32'(mem_we), 32'b1111);
    chk("s3_wdata", mem_wdata,   32'h11223344);
    tick();

    // LH 0x0011 misaligned
    request(1'b0, 16'h0011, 3'd1, 32'h0);
    chk("lh_mis",   32'(misaligned), 32'd1);
    chk("lh_en",    32'(mem_en),     32'd0);
    chk("lh_ready", 32'(req_ready),  32'd1);
    tick();
    chk("lh_mis_off", 32'(misaligned), 32'd0);
    chk("lh_en2",     32'(mem_en),     32'd0);

    // funct3=6 load is word-checked
    request(1'b0, 16'h0106, 3'd6, 32'h0);
    chk("f6_mis", 32'(misaligned), 32'd1);
    chk("f6_en",  32'(mem_en),     32'd0);
    tick();

    // Timeout with no data
    request(1'b0, 16'h0040, 3'd2, 32'h0);
    for (int i = 0; i < TIMEOUT; i++) tick();
    chk("to_pre_stall", 32'(stall),   32'd1);
    chk("to_pre_to",    32'(timeout), 32'd0);
    tick();
    chk("to_pulse",    32'(timeout),   32'd1);
    chk("to_ld_valid", 32'(ld_valid),  32'd0);
    chk("to_ready",    32'(req_ready), 32'd1);
    chk("to_ld_data",  ld_mem_data,    32'hDEADBEEF);
    chk("to_ld_addr",  32'(ld_addr),   32'h0104);
    tick();
    chk("to_pulse_off", 32'(timeout), 32'd0);

    // Data on the expiry cycle wins
    request(1'b0, 16'h0080, 3'd2, 32'h0);
    for (int i = 0; i < TIMEOUT; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("exp_ld_valid", 32'(ld_valid), 32'd1);
    chk("exp_timeout",  32'(timeout),  32'd0);
    chk("exp_ld_data",  ld_mem_data,   32'hCAFEF00D);
    chk("exp_ld_addr",  32'(ld_addr),  32'h0080);
    tick();
    chk("exp_idle", 32'(req_ready), 32'd1);

    // Reset during WAIT
    request(1'b0, 16'h0090, 3'd2, 32'h0);
    tick();
    chk("rw_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_stall0",  32'(stall),     32'd0);
    chk("rw_ready0",  32'(req_ready), 32'd0);
    chk("rw_en0",     32'(mem_en),    32'd0);
    chk("rw_data0",   ld_mem_data,    32'd0);
    chk("rw_addr0",   32'(ld_addr),   32'd0);
    chk("rw_func30",  32'(ld_func3),  32'd0);
    chk("rw_valid0",  32'(ld_valid),  32'd0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_post_valid", 32'(ld_valid),  32'd0);
    chk("rw_post_ready", 32'(req_ready), 32'd1);
    chk("rw_post_data",  ld_mem_data,    32'd0);
    tick();
    chk("rw_post_valid2", 32'(ld_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
